cntr_delay_arbiter: RTL and testbench

Shared-counter delay scheduler. Up to N_REQ requesters each ask for a delay of 1–16 clock cycles. The block grants them one at a time in round-robin order and times each granted delay on a single internal four_bit_sync_cntr. It drives the counter only through its enable input. The counter is never cleared except by rstn, so the controller times each delay relative to the free-running count value.

---
 rtl/cntr_arb_pkg.sv | 15 +
 rtl/four_bit_sync_cntr.sv | 29 ++
 rtl/cntr_delay_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cntr_delay_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cntr_arb_pkg.sv
// Shared definitions for the shared-counter delay arbiter: FSM state
// encoding and the counter and requester sizing constants.
package cntr_arb_pkg;

  localparam int CNT_W   = 4;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/four_bit_sync_cntr.sv
// Free-running 4-bit up counter with enable. It is cleared only by the
// asynchronous reset. carry flags the enabled 15->0 rollover.
module four_bit_sync_cntr
  import cntr_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             carry
);

  logic [CNT_W-1:0] count_r;

  // Count register: advance by one on every enabled cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r <= 4'd0;
    end else if (en) begin
      count_r <= count_r + 4'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign carry = en & (count_r == 4'd15);

endmodule

// File: rtl/cntr_delay_arbiter.sv
// Round-robin delay scheduler. Each granted delay is timed against a single
// free-running counter by comparing against a target latched at grant time.
module cntr_delay_arbiter
  import cntr_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req,
  input  logic [CNT_W*N_REQ-1:0] len,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   cnt_en,
  output logic [CNT_W-1:0]       count
);

  arb_state_e       state_r, next_state_s;
  logic [IDX_W-1:0] idx_r, ptr_r, win_idx_s;
  logic             win_valid_s;
  logic [CNT_W-1:0] target_r, len_sel_s, count_s;
  logic             cnt_en_s, run_exit_s, carry_unused_s;
  logic [N_REQ-1:0] grant_r, done_r, grant_nxt_s, done_nxt_s;
  logic             busy_r, busy_nxt_s;
  int               rank_s, best_rank_s;

  four_bit_sync_cntr u_cntr (
    .clk   (clk),
    .rstn  (rstn),
    .en    (cnt_en_s),
    .count (count_s),
    .carry (carry_unused_s)
  );

  // Round-robin winner: rank 0 is the requester just after ptr
  always_comb begin
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    best_rank_s = N_REQ;
    rank_s      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i > int'(ptr_r)) begin
        rank_s = i - int'(ptr_r) - 1;
      end else begin
        rank_s = i + N_REQ - int'(ptr_r) - 1;
      end
      if (req[i] && (rank_s < best_rank_s)) begin
        best_rank_s = rank_s;
        win_valid_s = 1'b1;
        win_idx_s   = IDX_W'(i);
      end else begin
        best_rank_s = best_rank_s;
      end
    end
  end

  // Length field of the current winner
  always_comb begin
    len_sel_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      len_sel_s = (win_idx_s == IDX_W'(i)) ? len[i*CNT_W +: CNT_W] : len_sel_s;
    end
  end

  // The final enabled cycle is the one whose increment lands on the target
  assign run_exit_s = ((count_s + 4'd1) == target_r);
  assign cnt_en_s   = (state_r == RUN);

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_valid_s) next_state_s = RUN;
        else             next_state_s = IDLE;
      end
      RUN: begin
        if (run_exit_s) next_state_s = DONE;
        else            next_state_s = RUN;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode, registered below
  always_comb begin
    grant_nxt_s = '0;
    done_nxt_s  = '0;
    case (state_r)
      IDLE: begin
        for (int i = 0; i < N_REQ; i++) begin
          grant_nxt_s[i] = win_valid_s && (win_idx_s == IDX_W'(i));
        end
      end
      RUN: begin
        for (int i = 0; i < N_REQ; i++) begin
          grant_nxt_s[i] = !run_exit_s && grant_r[i];
          done_nxt_s[i]  = run_exit_s && (idx_r == IDX_W'(i));
        end
      end
      DONE: begin
        grant_nxt_s = '0;
        done_nxt_s  = '0;
      end
      default: begin
        grant_nxt_s = '0;
        done_nxt_s  = '0;
      end
    endcase
    busy_nxt_s = (next_state_s != IDLE);
  end

  // Grant bookkeeping: winner index, end target, and round-robin pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_r    <= '0;
      target_r <= 4'd0;
      ptr_r    <= IDX_W'(N_REQ - 1);
    end else begin
      if ((state_r == IDLE) && win_valid_s) begin
        idx_r    <= win_idx_s;
        target_r <= count_s + len_sel_s;
      end else begin
        idx_r    <= idx_r;
        target_r <= target_r;
      end
      ptr_r <= (state_r == DONE) ? idx_r : ptr_r;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant_r <= '0;
      done_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      grant_r <= grant_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign grant  = grant_r;
  assign done   = done_r;
  assign busy   = busy_r;
  assign cnt_en = cnt_en_s;
  assign count  = count_s;

endmodule

// File: tb/tb_cntr_delay_arbiter.sv
// Self-checking bench for cntr_delay_arbiter: directed scenarios plus random
// traffic against a transaction-level schedule model.
module tb_cntr_delay_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] req;
  logic [4*N-1:0] len;
  logic [N-1:0] grant, done;
  logic         busy, cnt_en;
  logic [3:0]   count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: one transaction at a time, described by owner, sample cycle, length
  int m_active, m_owner, m_start, m_L, m_ptr, m_count;
  logic [2*N+5:0] exp_vec, act_vec;
  logic [N-1:0]   a_grant, a_done;
  logic           a_cnt_en;
  logic [3:0]     a_count;

  always #5 clk = ~clk;

  cntr_delay_arbiter #(.N_REQ(N)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .len    (len),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .cnt_en (cnt_en),
    .count  (count)
  );

  task automatic model_reset();
    m_active = 0; m_owner = 0; m_start = 0; m_L = 0;
    m_ptr = N - 1; m_count = 0;
  endtask

  // One clock cycle: sample at negedge, predict, advance model, step past posedge
  task automatic tick();
    logic [N-1:0] eg, ed;
    logic eb, ee;
    bit found;
    logic [3:0] nib;
    @(negedge clk);
    eg = '0; ed = '0; eb = 1'b0; ee = 1'b0;
    if (m_active != 0 && cyc > m_start + m_L + 1) begin
      m_active = 0;
      m_ptr = m_owner;
    end
    if (m_active != 0) begin
      if (cyc <= m_start + m_L) begin
        eg[m_owner] = 1'b1; ee = 1'b1; eb = 1'b1;
      end else begin
        ed[m_owner] = 1'b1; eb = 1'b1;
      end
    end
    exp_vec = {eg, ed, eb, ee, 4'(m_count)};
    act_vec = {grant, done, busy, cnt_en, count};
    a_grant = grant; a_done = done; a_cnt_en = cnt_en; a_count = count;
    if (m_active == 0 && req != '0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!found && req[j]) begin
          found = 1'b1;
          m_owner = j;
        end
      end
      nib = len[4*m_owner +: 4];
      m_L = (nib == 4'd0) ? 16 : int'(nib);
      m_start = cyc;
      m_active = 1;
    end
    if (ee) m_count = (m_count + 1) % 16;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    #2;
    model_reset();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = '0; len = '0;
    #12;
    tests++;
    if ({grant, done, busy, cnt_en, count} !== '0) begin
      fails++;
      $display("FAIL reset_state got=%h exp=0", {grant, done, busy, cnt_en, count});
    end
    rstn = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_basic();
    req = 4'b0001; len = 16'h0003;
    for (int i = 0; i < 7; i++) begin
      tick();
      req = '0;
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    tests++;
    if (count !== 4'd3) begin
      fails++;
      $display("FAIL basic_count got=%0d exp=3", count);
    end
  endtask

  task automatic test_wrap();
    int seen;
    seen = 0;
    req = 4'b0001;
    len = '0;
    len[3:0] = 4'((14 - m_count) & 15);
    for (int i = 0; i < 20; i++) begin
      tick();
      req = '0;
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL wrap_setup cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    tests++;
    if (count !== 4'd14) begin
      fails++;
      $display("FAIL wrap_start got=%0d exp=14", count);
    end
    req = 4'b0010; len = 16'h0050;
    for (int i = 0; i < 9; i++) begin
      tick();
      req = '0;
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      if (a_done[1]) begin
        seen++;
        tests++;
        if (a_count !== 4'd3) begin
          fails++;
          $display("FAIL wrap_done_count got=%0d exp=3", a_count);
        end
      end
    end
    tests++;
    if (seen != 1) begin
      fails++;
      $display("FAIL wrap_done_pulses got=%0d exp=1", seen);
    end
  endtask

  task automatic test_len0();
    int en_cycles, dones;
    logic [3:0] start;
    en_cycles = 0; dones = 0;
    start = count;
    req = 4'b0100; len = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      req = '0;
      if (a_cnt_en) en_cycles++;
      if (a_done[2]) dones++;
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL len0 cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    tests++;
    if (en_cycles != 16 || dones != 1 || count !== start) begin
      fails++;
      $display("FAIL len0_summary got=%0d/%0d/%0d exp=16/1/%0d", en_cycles, dones, count, start);
    end
  endtask

  task automatic test_round_robin(input logic [N-1:0] pattern, input int e0, input int e1,
                                  input int e2, input int e3, input int e4);
    int order[$];
    int expd[5];
    logic [N-1:0] prev;
    expd = '{e0, e1, e2, e3, e4};
    apply_reset();
    prev = '0;
    req = pattern; len = 16'h1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL rr cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
      if (a_grant != '0 && prev == '0) begin
        for (int b = 0; b < N; b++) if (a_grant[b]) order.push_back(b);
      end
      prev = a_grant;
    end
    req = '0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= order.size() || order[i] != expd[i]) begin
        fails++;
        $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i,
                 (i < order.size()) ? order[i] : -1, expd[i]);
      end
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones = 0;
    req = 4'b0001; len = 16'h0008;
    tick();
    req = '0;
    tick();
    #2;
    rstn = 1'b0;
    #1;
    tests++;
    if ({grant, busy, cnt_en, count} !== '0) begin
      fails++;
      $display("FAIL midrun_reset got=%h exp=0", {grant, busy, cnt_en, count});
    end
    model_reset();
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (a_done != '0) dones++;
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL midrun_after cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    tests++;
    if (dones != 0) begin
      fails++;
      $display("FAIL midrun_no_done got=%0d exp=0", dones);
    end
    req = 4'b1110; req[0] = 1'b1; len = 16'h2222;
    tick();
    tick();
    req = '0;
    tests++;
    if (a_grant !== 4'b0001) begin
      fails++;
      $display("FAIL midrun_next_grant got=%b exp=0001", a_grant);
    end
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_drop_change();
    int en_cycles, dones;
    en_cycles = 0; dones = 0;
    req = 4'b1000; len = 16'h6000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) begin
        req = '0;
        len = 16'h2000;
      end
      if (a_cnt_en) en_cycles++;
      if (a_done[3]) dones++;
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL drop cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    tests++;
    if (en_cycles != 6 || dones != 1) begin
      fails++;
      $display("FAIL drop_summary got=%0d/%0d exp=6/1", en_cycles, dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) req = '0;
      len = 16'($urandom);
      tick();
      tests++;
      if (act_vec !== exp_vec) begin
        fails++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, act_vec, exp_vec);
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len0();
    test_reset_mid_run();
    test_drop_change();
    test_round_robin(4'b1111, 0, 1, 2, 3, 0);
    test_round_robin(4'b0101, 0, 2, 0, 2, 0);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
